cnt_match: RTL
==============

Name: cnt_match

Overview:
- Parametrised successor to the fixed 12-input AND-match used for video counter compares.
- Holds a free-running WIDTH-bit counter with programmable period and NCH independent equality-compare channels.
- Each channel reduces its per-bit XNOR vector through a registered GROUP-wide NAND stage, followed by a NOR stage, which keeps wide compares off the critical path.
- Each channel produces a level match and a pulse-mode or sticky-mode hit flag, for video line/pixel event generation.

Parameters:
- WIDTH, 12, counter and compare width in bits (≥1).
- NCH, 2, number of compare channels (≥1).
- GROUP, 6, inputs per first-level NAND group; NGRP = ceil(WIDTH/GROUP).

Ports:
- sys_clk  in  1  system clock, rising edge.
- resetl  in  1  asynchronous active-low reset.
- en  in  1  counter advance enable.
- load  in  1  synchronous counter clear; takes priority over en.
- period  in  WIDTH  terminal count, inclusive; the counter wraps to 0 after reaching it.
- cmp_val  in  NCH*WIDTH  channel i compare value at bits [i*WIDTH +: WIDTH].
- mode  in  NCH  per channel: 0 = pulse hit, 1 = sticky hit.
- ack  in  NCH  per-channel sticky clear.
- count  out  WIDTH  current counter value (registered).
- match  out  NCH  level equality flag, one cycle delayed.
- hit  out  NCH  event flag.

Behaviour:
- Reset (resetl low, asynchronous):
  - count = 0, all group registers = 0, match = 0, match_d = 0, hit = 0.
  - Deassertion is synchronous to sys_clk (external synchroniser).
  - Reset mid-operation aborts everything; no pending hit survives.
- Counter, evaluated per edge:
  - load=1 → 0.
  - else en=1 and count==period → 0.
  - else en=1 → count+1.
  - else hold.
  - period=0 → count stays 0.
  - Wrap uses unsigned WIDTH-bit arithmetic; count never exceeds period unless period is lowered below the current count. In that case it runs up to 2^WIDTH-1, wraps naturally to 0, then obeys period.
- Compare pipeline, per channel i:
  - Stage 1 (registered): g[i][k] = ~&(XNOR of count and cmp_val bits within group k), i.e. 1 = "group mismatch".
  - The last partial group is padded with 1s, so padding never causes a mismatch.
  - Stage 2 (combinational from stage-1 registers): match[i] = ~|g[i].
  - Latency: match[i] is high in cycle N+1 iff count==cmp_val_i was true in cycle N.
  - cmp_val is sampled each cycle; a change takes effect with the same one-cycle latency.
  - The compare runs independently of en: if count holds at the compare value, match stays high.
- match_d[i]: registered copy of match[i]; rise[i] = match[i] & ~match_d[i].
- Hit, mode 0 (pulse):
  - hit[i] registered = rise[i]; a one-cycle pulse two cycles after the equality cycle.
  - Held counts do not repeat the pulse.
- Hit, mode 1 (sticky):
  - hit[i] set on rise[i], cleared on ack[i].
  - Simultaneous set and ack → set wins (hit stays 1).
  - ack with hit=0 has no effect.
- Mode change while hit=1 in sticky: switching to pulse clears hit on the next edge unless rise is present.
- cmp_val > period → channel never matches while period is honoured.
- Channels are fully independent; identical cmp_val on two channels gives identical timing.

Decomposition:
- Shared package: function for NGRP (ceil divide), mode encodings MODE_PULSE=0 and MODE_STICKY=1.
- One sub-module, cnt_match_ch: per-channel group-NAND register stage, NOR reduce, match_d, hit logic.
  - Parameters: WIDTH, GROUP.
  - Instantiated NCH times by generate.
- The counter stays in the top level.

Test Plan:
1. Reset: assert resetl=0 mid-count at count=37 with hit[0]=1 sticky → count, match and hit all 0 immediately (async), before the next edge.
2. Wrap: period=5, en=1 → count sequence 0,1,2,3,4,5,0,1; load=1 at count=3 with en=1 → next count 0.
3. Latency: cmp_val0=4, mode0=0, en=1 → match[0] high in the cycle after count=4, hit[0] one-cycle pulse in the cycle after that; en=0 holding count=4 for 5 cycles → match stays high, no second pulse.
4. Sticky/ack: cmp_val1=2, mode1=1 → hit[1] sets and stays high across wraps; ack[1]=1 → clears; ack[1] on the same edge as a new rise → hit stays 1.
5. Widths: WIDTH=13, GROUP=6 (partial third group, 1 bit); cmp_val=0x1000, period=0x1FFF → match only at count 0x1000, never at 0x0000.
6. Out of range: period=3, cmp_val=7 → no match over 20 cycles; NCH=3 with equal cmp_val=1 → all three match and hit bits cycle-identical.

Source files
------------

// File: rtl/cnt_match_pkg.sv
// Shared definitions for the counter/compare slice: hit-mode encodings and
// the group-count helper used to size the first-level NAND stage.
package cnt_match_pkg;

   localparam logic MODE_PULSE  = 1'b0;
   localparam logic MODE_STICKY = 1'b1;

   // Number of GROUP-wide NAND groups needed to cover a WIDTH-bit compare.
   function automatic int ngrp(input int width, input int group);
      return (width + group - 1) / group;
   endfunction

endpackage

// File: rtl/cnt_match_if.sv
// Bus bundle between the controller and cnt_match: counter controls, per-channel
// compare setup, and the registered count / match / hit results.
interface cnt_match_if #(
   parameter int WIDTH = 12,
   parameter int NCH   = 2
);
   // No valid/ready handshake here: every input is sampled on each rising
   // edge, and ack[i] is a one-cycle request that clears a sticky hit[i].
   logic                   en;
   logic                   load;
   logic [WIDTH-1:0]       period;
   logic [NCH*WIDTH-1:0]   cmp_val;
   logic [NCH-1:0]         mode;
   logic [NCH-1:0]         ack;
   logic [WIDTH-1:0]       count;
   logic [NCH-1:0]         match;
   logic [NCH-1:0]         hit;

   modport master (
      output en, load, period, cmp_val, mode, ack,
      input  count, match, hit
   );

   modport slave (
      input  en, load, period, cmp_val, mode, ack,
      output count, match, hit
   );

endinterface

// File: rtl/cnt_match_ch.sv
// One compare channel: registered GROUP-wide NAND mismatch stage, NOR reduce
// to a level match, edge detect and pulse/sticky hit flag.
module cnt_match_ch
   import cnt_match_pkg::*;
#(
   parameter int WIDTH = 12,
   parameter int GROUP = 6
) (
   input  logic             sys_clk,
   input  logic             resetl,
   input  logic [WIDTH-1:0] count,
   input  logic [WIDTH-1:0] cmp_val,
   input  logic             mode,
   input  logic             ack,
   output logic             match,
   output logic             hit
);

   localparam int NGRP = ngrp(WIDTH, GROUP);
   localparam int PADW = NGRP * GROUP;

   logic [PADW-1:0] eq_pad;
   logic [NGRP-1:0] g_next;
   logic [NGRP-1:0] g_q;
   logic            primed_q;
   logic            match_d_q;
   logic            hit_q;
   logic            hit_next;
   logic            rise;

   // Padding bits read as "equal" so a partial last group never mismatches.
   always_comb begin
      eq_pad             = '1;
      eq_pad[WIDTH-1:0]  = ~(count ^ cmp_val);
   end

   always_comb begin
      g_next = '0;
      for (int k = 0; k < NGRP; k++) begin
         g_next[k] = ~&eq_pad[k*GROUP +: GROUP];
      end
   end

   // primed_q masks the all-zero group register image right after reset,
   // which would otherwise read as a spurious match.
   assign match = primed_q & ~|g_q;
   assign rise  = match & ~match_d_q;

   always_comb begin
      hit_next = 1'b0;
      if (rise) begin
         hit_next = 1'b1;
      end else if (mode == MODE_STICKY && !ack) begin
         hit_next = hit_q;
      end
   end

   always_ff @(posedge sys_clk or negedge resetl) begin
      if (!resetl) begin
         g_q       <= '0;
         primed_q  <= 1'b0;
         match_d_q <= 1'b0;
         hit_q     <= 1'b0;
      end else begin
         g_q       <= g_next;
         primed_q  <= 1'b1;
         match_d_q <= match;
         hit_q     <= hit_next;
      end
   end

   assign hit = hit_q;

endmodule

// File: rtl/cnt_match.sv
// Free-running programmable-period counter feeding NCH independent
// pipelined equality-compare channels for video line/pixel events.
module cnt_match
   import cnt_match_pkg::*;
#(
   parameter int WIDTH = 12,
   parameter int NCH   = 2,
   parameter int GROUP = 6
) (
   input  logic       sys_clk,
   input  logic       resetl,
   cnt_match_if.slave bus
);

   logic [WIDTH-1:0] count_q;

   // If period is lowered below count, the equality never hits and the
   // counter simply rolls over at 2^WIDTH before obeying the new period.
   always_ff @(posedge sys_clk or negedge resetl) begin
      if (!resetl) begin
         count_q <= '0;
      end else if (bus.load) begin
         count_q <= '0;
      end else if (bus.en) begin
         if (count_q == bus.period) count_q <= '0;
         else                       count_q <= count_q + WIDTH'(1);
      end
   end

   assign bus.count = count_q;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      cnt_match_ch #(
         .WIDTH (WIDTH),
         .GROUP (GROUP)
      ) u_ch (
         .sys_clk (sys_clk),
         .resetl  (resetl),
         .count   (count_q),
         .cmp_val (bus.cmp_val[i*WIDTH +: WIDTH]),
         .mode    (bus.mode[i]),
         .ack     (bus.ack[i]),
         .match   (bus.match[i]),
         .hit     (bus.hit[i])
      );
   end

endmodule
